// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: two writeback requesters (A = ALU,
// B = load) share one register-file write port. Grants are combinational
// and alternate under contention; the write port itself is registered.
module rf_write_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter bit          DROP_ZERO  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  hold,
  input  logic                  a_valid,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_data,
  output logic                  a_ready,
  input  logic                  b_valid,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_data,
  output logic                  b_ready,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  addr_conflict,
  output logic [15:0]           wr_count
);

  localparam int unsigned CNT_W = 16;

  // Round-robin priority pointer: which requester wins a tie next.
  typedef enum logic {
    PRI_A = 1'b0,
    PRI_B = 1'b1
  } pri_e;

  pri_e                  pri_q;
  pri_e                  pri_d;
  logic                  wr_en_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic [DATA_WIDTH-1:0] wr_data_q;
  logic                  conflict_q;
  logic [CNT_W-1:0]      wr_count_q;

  logic                  grant_a;
  logic                  grant_b;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  commit_d;
  logic                  conflict_d;

  // Grant selection: lone requester wins, ties go to the pointer; nothing
  // is granted during reset or hold.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (!rst && !hold) begin
      if (a_valid && (!b_valid || pri_q == PRI_A)) begin
        grant_a = 1'b1;
      end else if (b_valid) begin
        grant_b = 1'b1;
      end
    end
  end

  // Winning payload, commit qualification, pointer and conflict next-state.
  always_comb begin
    sel_addr   = grant_b ? b_addr : a_addr;
    sel_data   = grant_b ? b_data : a_data;
    // Address-0 writes are still handshaken but never reach the register file.
    commit_d   = (grant_a || grant_b) && !(DROP_ZERO && (sel_addr == '0));
    pri_d      = pri_q;
    if (grant_a) begin
      pri_d = PRI_B;
    end else if (grant_b) begin
      pri_d = PRI_A;
    end
    conflict_d = !hold && a_valid && b_valid && (a_addr == b_addr);
  end

  // Registered write port, pointer, conflict pulse and commit counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      pri_q      <= PRI_A;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      conflict_q <= 1'b0;
      wr_count_q <= '0;
    end else begin
      pri_q      <= pri_d;
      wr_en_q    <= commit_d;
      conflict_q <= conflict_d;
      if (commit_d) begin
        wr_addr_q  <= sel_addr;
        wr_data_q  <= sel_data;
        wr_count_q <= wr_count_q + CNT_W'(1);
      end
    end
  end

  assign a_ready       = grant_a;
  assign b_ready       = grant_b;
  assign wr_en         = wr_en_q;
  assign wr_addr       = wr_addr_q;
  assign wr_data       = wr_data_q;
  assign addr_conflict = conflict_q;
  assign wr_count      = wr_count_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter: reset, single write, contention,
// same-address conflict, hold, zero-address drop, counter wrap, mid-stream reset.
module tb_rf_write_arbiter;

  logic        clk;
  logic        rst;
  logic        hold;
  logic        a_valid;
  logic [4:0]  a_addr;
  logic [31:0] a_data;
  logic        a_ready;
  logic        b_valid;
  logic [4:0]  b_addr;
  logic [31:0] b_data;
  logic        b_ready;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        addr_conflict;
  logic [15:0] wr_count;

  int errors;
  int checks;

  rf_write_arbiter dut (
    .clk           (clk),
    .rst           (rst),
    .hold          (hold),
    .a_valid       (a_valid),
    .a_addr        (a_addr),
    .a_data        (a_data),
    .a_ready       (a_ready),
    .b_valid       (b_valid),
    .b_addr        (b_addr),
    .b_data        (b_data),
    .b_ready       (b_ready),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .addr_conflict (addr_conflict),
    .wr_count      (wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                       input logic bv, input logic [4:0] ba, input logic [31:0] bd);
    a_valid = av;
    a_addr  = aa;
    a_data  = ad;
    b_valid = bv;
    b_addr  = ba;
    b_data  = bd;
    #1;
  endtask

  initial begin
    int unsigned misses;
    errors  = 0;
    checks  = 0;
    rst     = 1'b1;
    hold    = 1'b0;
    a_valid = 1'b0;
    a_addr  = 5'd0;
    a_data  = 32'd0;
    b_valid = 1'b0;
    b_addr  = 5'd0;
    b_data  = 32'd0;

    // Reset state; readies suppressed while rst is high.
    tick();
    drive(1'b1, 5'd4, 32'h44, 1'b1, 5'd6, 32'h66);
    check("rst_a_ready", 32'(a_ready), 32'd0);
    check("rst_b_ready", 32'(b_ready), 32'd0);
    tick();
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    check("rst_wr_data", wr_data, 32'd0);
    check("rst_conflict", 32'(addr_conflict), 32'd0);
    check("rst_count", 32'(wr_count), 32'd0);
    rst = 1'b0;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    tick();
    check("idle_wr_en", 32'(wr_en), 32'd0);

    // Single write from A.
    drive(1'b1, 5'd3, 32'h5, 1'b0, 5'd0, 32'd0);
    check("single_a_ready", 32'(a_ready), 32'd1);
    check("single_b_ready", 32'(b_ready), 32'd0);
    tick();
    check("single_wr_en", 32'(wr_en), 32'd1);
    check("single_wr_addr", 32'(wr_addr), 32'd3);
    check("single_wr_data", wr_data, 32'h5);
    check("single_count", 32'(wr_count), 32'd1);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    tick();
    check("after_wr_en", 32'(wr_en), 32'd0);
    check("after_wr_addr_held", 32'(wr_addr), 32'd3);
    check("after_wr_data_held", wr_data, 32'h5);

    // Lone B write (pointer was PRI_B, now returns to PRI_A).
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h99);
    check("loneb_b_ready", 32'(b_ready), 32'd1);
    tick();
    check("loneb_wr_addr", 32'(wr_addr), 32'd9);
    check("loneb_count", 32'(wr_count), 32'd2);

    // Contention: A,B,A,B with fresh data after each grant.
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 5'd1, 32'hA0 + 32'(k / 2 + k % 2), 1'b1, 5'd2, 32'hB0 + 32'(k / 2));
      check("cont_a_ready", 32'(a_ready), 32'((k % 2) == 0));
      check("cont_b_ready", 32'(b_ready), 32'((k % 2) == 1));
      tick();
      check("cont_wr_en", 32'(wr_en), 32'd1);
      check("cont_wr_addr", 32'(wr_addr), (k % 2 == 0) ? 32'd1 : 32'd2);
      check("cont_wr_data", wr_data, (k % 2 == 0) ? 32'hA0 + 32'(k / 2) : 32'hB0 + 32'(k / 2));
      check("cont_count", 32'(wr_count), 32'(3 + k));
      check("cont_no_conflict", 32'(addr_conflict), 32'd0);
    end

    // Same-address conflict: A wins first, B's value lands last.
    drive(1'b1, 5'd7, 32'h11, 1'b1, 5'd7, 32'h22);
    check("conf_a_ready", 32'(a_ready), 32'd1);
    tick();
    check("conf_pulse", 32'(addr_conflict), 32'd1);
    check("conf_wr1_data", wr_data, 32'h11);
    check("conf_wr1_addr", 32'(wr_addr), 32'd7);
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h22);
    check("conf_b_ready", 32'(b_ready), 32'd1);
    tick();
    check("conf_pulse_end", 32'(addr_conflict), 32'd0);
    check("conf_wr2_data", wr_data, 32'h22);
    check("conf_count", 32'(wr_count), 32'd8);

    // Hold: no grants, no writes, no conflict pulse, port keeps last values.
    hold = 1'b1;
    drive(1'b1, 5'd5, 32'h77, 1'b1, 5'd5, 32'h55);
    check("hold_both_a_ready", 32'(a_ready), 32'd0);
    tick();
    check("hold_no_conflict", 32'(addr_conflict), 32'd0);
    check("hold_wr_en0", 32'(wr_en), 32'd0);
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h55);
    for (int k = 0; k < 3; k++) begin
      check("hold_b_ready", 32'(b_ready), 32'd0);
      tick();
      check("hold_wr_en", 32'(wr_en), 32'd0);
      check("hold_wr_data_held", wr_data, 32'h22);
    end
    hold = 1'b0;
    #1;
    check("unhold_b_ready", 32'(b_ready), 32'd1);
    tick();
    check("unhold_wr_addr", 32'(wr_addr), 32'd5);
    check("unhold_wr_data", wr_data, 32'h55);
    check("unhold_count", 32'(wr_count), 32'd9);

    // Zero-address drop: handshake completes, nothing committed.
    drive(1'b1, 5'd0, 32'hDEAD, 1'b0, 5'd0, 32'd0);
    check("zero_a_ready", 32'(a_ready), 32'd1);
    tick();
    check("zero_wr_en", 32'(wr_en), 32'd0);
    check("zero_count", 32'(wr_count), 32'd9);
    check("zero_wr_addr_held", 32'(wr_addr), 32'd5);

    // Back-to-back lone A writes up to 16'hFFFF, then one more to wrap.
    misses = 0;
    for (int i = 0; i < 65535 - 9; i++) begin
      drive(1'b1, 5'd1, 32'(i), 1'b0, 5'd0, 32'd0);
      if (a_ready !== 1'b1) misses++;
      tick();
      if (wr_en !== 1'b1) misses++;
    end
    check("stream_misses", misses, 32'd0);
    check("preload_count", 32'(wr_count), 32'hFFFF);
    drive(1'b1, 5'd2, 32'hCAFE, 1'b0, 5'd0, 32'd0);
    tick();
    check("wrap_wr_en", 32'(wr_en), 32'd1);
    check("wrap_count", 32'(wr_count), 32'd0);

    // Reset during a would-be grant (pointer is PRI_B here).
    rst = 1'b1;
    drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44);
    check("midrst_a_ready", 32'(a_ready), 32'd0);
    check("midrst_b_ready", 32'(b_ready), 32'd0);
    tick();
    check("midrst_wr_en", 32'(wr_en), 32'd0);
    check("midrst_wr_addr", 32'(wr_addr), 32'd0);
    rst = 1'b0;
    #1;
    check("postrst_a_ready", 32'(a_ready), 32'd1);
    check("postrst_b_ready", 32'(b_ready), 32'd0);
    tick();
    check("postrst_wr_addr", 32'(wr_addr), 32'd3);
    check("postrst_count", 32'(wr_count), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rf_write_arbiter.md
RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, width of write data.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 5, width of register address (32 registers).
REQ-003 The block SHALL have parameter DROP_ZERO, default 1; when 1, writes to address 0 are accepted but discarded.
REQ-004 The block SHALL have these ports:
- clk  input  1  single clock; all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- hold  input  1  stalls arbitration; no grants while high.
- a_valid  input  1  requester A (ALU writeback) has a write.
- a_addr  input  ADDR_WIDTH  requester A destination.
- a_data  input  DATA_WIDTH  requester A data.
- a_ready  output  1  A's write accepted this cycle.
- b_valid  input  1  requester B (load writeback) has a write.
- b_addr  input  ADDR_WIDTH  requester B destination.
- b_data  input  DATA_WIDTH  requester B data.
- b_ready  output  1  B's write accepted this cycle.
- wr_en  output  1  register-file write enable.
- wr_addr  output  ADDR_WIDTH  register-file write address.
- wr_data  output  DATA_WIDTH  register-file write data.
- addr_conflict  output  1  one-cycle pulse: both requested the same address.
- wr_count  output  16  committed-write counter.

Function
REQ-005 A transfer SHALL occur on a requester in any cycle where its valid and ready are both high; requesters SHALL hold valid/addr/data stable until ready.
REQ-006 a_ready and b_ready SHALL be combinational from valid, hold and the priority pointer; at most one SHALL be high per cycle.
REQ-007 With hold low, a lone valid requester SHALL be granted in the same cycle.
REQ-008 With hold low and both valid, the requester selected by the priority pointer SHALL be granted.
REQ-009 The priority pointer SHALL be a 1-bit state PRI_A/PRI_B: after a grant to A it SHALL become PRI_B, after a grant to B it SHALL become PRI_A, and with no grant it SHALL be unchanged.
REQ-010 With hold high, a_ready and b_ready SHALL be 0 and the pointer SHALL be unchanged.
REQ-011 wr_en/wr_addr/wr_data SHALL be registered: one cycle after a transfer, wr_en=1 with that transfer's addr/data; otherwise wr_en=0 and wr_addr/wr_data hold their last values.
REQ-012 When DROP_ZERO=1 and the transferred address is 0, the transfer SHALL complete (ready high) but the following cycle SHALL have wr_en=0 and wr_count SHALL NOT increment.
REQ-013 wr_count SHALL increment by 1 in the cycle wr_en goes high and SHALL wrap from 16'hFFFF to 0.
REQ-014 addr_conflict SHALL pulse high, registered, one cycle after any cycle with hold low, a_valid=b_valid=1 and a_addr==b_addr. The losing requester SHALL be written in a later cycle, so its value is the final register contents.
REQ-015 Back-to-back transfers SHALL be supported: sustained throughput is one write per cycle.

Reset
REQ-016 On rst high at a rising edge, the block SHALL set wr_en=0, wr_addr=0, wr_data=0, addr_conflict=0, wr_count=0 and the pointer to PRI_A.
REQ-017 While rst is high, a_ready and b_ready SHALL be 0.
REQ-018 A transfer accepted in the cycle before rst asserts SHALL be discarded; wr_en SHALL be 0 in the cycle after reset.

Verification
REQ-019 Single write: a_valid=1, a_addr=3, a_data=0x5 (hold=0, after reset) -> a_ready=1 that cycle; next cycle wr_en=1, wr_addr=3, wr_data=0x5, then wr_count=1.
REQ-020 Contention: a_valid=b_valid=1 for 4 cycles, addresses 1/2, fresh data each grant -> grants in the order A,B,A,B; wr_en high for 4 consecutive cycles.
REQ-021 Conflict: a_addr=b_addr=7 both valid, a_data=0x11, b_data=0x22, pointer PRI_A -> addr_conflict pulses once; writes to 7 occur 0x11 then 0x22.
REQ-022 Hold: hold=1 for 3 cycles with b_valid=1 -> b_ready=0 and wr_en=0 throughout; hold drops -> b_ready=1 that cycle.
REQ-023 Zero drop: a_valid=1, a_addr=0, DROP_ZERO=1 -> a_ready=1; next cycle wr_en=0 and wr_count unchanged.
REQ-024 Reset mid-stream plus wrap: preload wr_count=16'hFFFF via 65535 writes, then one write -> wr_count=0; assert rst during a grant -> no wr_en next cycle, and the pointer returns to PRI_A.
